// File: rtl/gcd_pkg.sv
// gcd_pkg: shared definitions for the GCD AXI4-Lite peripheral.
//   - register byte offsets and CTRL/STATUS bit positions
//   - engine state enumeration (IDLE, CALC, DONE)
//   - AXI response code and a byte-strobe merge helper
package gcd_pkg;

  localparam int REG_W = 32;

  // Byte offsets of the four 32-bit registers.
  localparam logic [3:0] OFFS_OPA    = 4'h0;
  localparam logic [3:0] OFFS_OPB    = 4'h4;
  localparam logic [3:0] OFFS_CTRL   = 4'h8;
  localparam logic [3:0] OFFS_RESULT = 4'hC;

  // CTRL (write) / STATUS (read) bit positions.
  localparam int CTRL_START_BIT  = 0;
  localparam int STATUS_BUSY_BIT = 1;
  localparam int STATUS_DONE_BIT = 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gcd_state_e;

  // Replace only the bytes of old_val whose strobe bit is set.
  function automatic logic [REG_W-1:0] apply_wstrb(
    input logic [REG_W-1:0]   old_val,
    input logic [REG_W-1:0]   new_val,
    input logic [REG_W/8-1:0] strb
  );
    logic [REG_W-1:0] res;
    res = old_val;
    for (int i = 0; i < REG_W / 8; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/gcd_axil_slave_if.sv
// gcd_axil_slave_if: AXI4-Lite bus bundle for the GCD peripheral.
//   Carries the five AXI4-Lite channels (AW, W, B, AR, R).
//   master modport: drives requests, receives responses (testbench/CPU side)
//   slave  modport: the peripheral side
interface gcd_axil_slave_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;

  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;

  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;

  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;

  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

endinterface

// File: rtl/gcd_core.sv
// gcd_core: subtractive GCD engine.
//   clk, reset : clock, asynchronous active-high reset
//   start      : load a/b and begin (honoured in IDLE or DONE only)
//   a, b       : operands sampled on an accepted start
//   busy       : engine is in CALC
//   done       : engine is in DONE (sticky until the next start)
//   result     : last computed GCD, held until the next DONE
module gcd_core
  import gcd_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [REG_W-1:0] a,
  input  logic [REG_W-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [REG_W-1:0] result
);

  gcd_state_e       state_q, state_d;
  logic [REG_W-1:0] a_q, a_d;
  logic [REG_W-1:0] b_q, b_d;
  logic [REG_W-1:0] result_q, result_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          state_d = CALC;
        end
      end
      CALC: begin
        // A zero operand or equal operands ends the run; the larger one is
        // the GCD (covers gcd(0,x)=x and gcd(0,0)=0).
        if (a_q == '0 || b_q == '0 || a_q == b_q) begin
          result_d = (a_q > b_q) ? a_q : b_q;
          state_d  = DONE;
        end else if (a_q > b_q) begin
          a_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q == CALC);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: rtl/gcd_axil_slave.sv
// gcd_axil_slave: AXI4-Lite register front end for the GCD engine.
//   ACLK, ARESET : clock, asynchronous active-high reset
//   s_axi        : AXI4-Lite slave bundle
//   irq          : level interrupt, high while the engine is in DONE
// Registers (addr[3:2]): 0x0 OPA RW, 0x4 OPB RW, 0x8 CTRL(W)/STATUS(R),
// 0xC RESULT RO. All responses are OKAY.
module gcd_axil_slave
  import gcd_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
)
(
  input  logic              ACLK,
  input  logic              ARESET,
  gcd_axil_slave_if.slave   s_axi,
  output logic              irq
);

  logic             ready_en_q, ready_en_d;
  logic             aw_held_q, aw_held_d;
  logic [3:0]       awaddr_q, awaddr_d;
  logic             w_held_q, w_held_d;
  logic [REG_W-1:0] wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             bvalid_q, bvalid_d;
  logic             rvalid_q, rvalid_d;
  logic [REG_W-1:0] rdata_q, rdata_d;
  logic [REG_W-1:0] opa_q, opa_d;
  logic [REG_W-1:0] opb_q, opb_d;

  logic             awready, wready, arready;
  logic             aw_hs, w_hs, ar_hs, wr_commit;
  logic             start;
  logic             busy, done;
  logic [REG_W-1:0] result;
  logic [REG_W-1:0] status;
  logic [3:0]       araddr;
  logic             unused_axi;

  gcd_core u_core (
    .clk    (ACLK),
    .reset  (ARESET),
    .start  (start),
    .a      (opa_q),
    .b      (opb_q),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ready_en_q <= 1'b0;
      aw_held_q  <= 1'b0;
      awaddr_q   <= '0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
    end else begin
      ready_en_q <= ready_en_d;
      aw_held_q  <= aw_held_d;
      awaddr_q   <= awaddr_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
    end
  end

  // ready_en_q keeps every READY low until the first edge after reset.
  assign awready = ready_en_q & ~aw_held_q & ~bvalid_q;
  assign wready  = ready_en_q & ~w_held_q  & ~bvalid_q;
  assign arready = ready_en_q & ~rvalid_q;

  assign aw_hs     = s_axi.S_AXI_AWVALID & awready;
  assign w_hs      = s_axi.S_AXI_WVALID  & wready;
  assign ar_hs     = s_axi.S_AXI_ARVALID & arready;
  assign wr_commit = aw_held_q & w_held_q;

  assign araddr = {s_axi.S_AXI_ARADDR[3:2], 2'b00};

  always_comb begin
    status                  = '0;
    status[STATUS_BUSY_BIT] = busy;
    status[STATUS_DONE_BIT] = done;
  end

  always_comb begin
    ready_en_d = 1'b1;
    aw_held_d  = aw_held_q;
    awaddr_d   = awaddr_q;
    w_held_d   = w_held_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    start      = 1'b0;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = {s_axi.S_AXI_AWADDR[3:2], 2'b00};
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi.S_AXI_WDATA;
      wstrb_d  = s_axi.S_AXI_WSTRB;
    end

    // Both halves captured: apply the write and raise BVALID next cycle.
    // READYs are already low here, so no new handshake can overlap.
    if (wr_commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      case (awaddr_q)
        OFFS_OPA:  opa_d = apply_wstrb(opa_q, wdata_q, wstrb_q);
        OFFS_OPB:  opb_d = apply_wstrb(opb_q, wdata_q, wstrb_q);
        OFFS_CTRL: start = wdata_q[CTRL_START_BIT];
        default:   ;
      endcase
    end else if (bvalid_q && s_axi.S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end

    // Read data is sampled from current register state, so a read that
    // coincides with a commit sees the pre-write value.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      case (araddr)
        OFFS_OPA:  rdata_d = opa_q;
        OFFS_OPB:  rdata_d = opb_q;
        OFFS_CTRL: rdata_d = status;
        default:   rdata_d = result;
      endcase
    end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  assign s_axi.S_AXI_AWREADY = awready;
  assign s_axi.S_AXI_WREADY  = wready;
  assign s_axi.S_AXI_BRESP   = RESP_OKAY;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_ARREADY = arready;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = RESP_OKAY;
  assign s_axi.S_AXI_RVALID  = rvalid_q;

  assign irq = done;

  // Protection bits and byte-lane address bits carry no meaning here.
  assign unused_axi = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                        s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_gcd_axil_slave.sv
module tb_gcd_axil_slave;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic irq;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  // Reference model state
  logic [31:0] m_opa = '0, m_opb = '0, m_result = '0;
  logic        m_busy = 1'b0, m_done = 1'b0;

  gcd_axil_slave_if #(.ADDR_W(4), .DATA_W(32)) bus ();

  gcd_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .s_axi  (bus.slave),
    .irq    (irq)
  );

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  // CALC cycles = sum of Euclid quotients (each quotient is that many subtractions,
  // the last one replaced by the equality-detect cycle); 1 if an operand is zero.
  function automatic int ref_latency(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, t;
    int s;
    if (a == 0 || b == 0) return 1;
    x = a; y = b; s = 0;
    while (y != 0) begin s += int'(x / y); t = x % y; x = y; y = t; end
    return s;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = s[i] ? n[i*8 +: 8] : o[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_status();
    return {29'd0, m_done, m_busy, 1'b0};
  endfunction

  function automatic void model_reset();
    m_opa = '0; m_opb = '0; m_result = '0; m_busy = 1'b0; m_done = 1'b0;
  endfunction

  // ---------------- bus drivers ----------------
  task automatic step();
    @(posedge ACLK); #1;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output int t_b, output logic [1:0] bresp,
                           output logic b_after, output logic b_stable);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int k = 0;
    bus.S_AXI_AWADDR = addr;
    bus.S_AXI_AWPROT = 3'($urandom);
    bus.S_AXI_WDATA  = data;
    bus.S_AXI_WSTRB  = strb;
    while (!(aw_done && w_done) && k < 64) begin
      bus.S_AXI_AWVALID = !aw_done && k >= aw_dly;
      bus.S_AXI_WVALID  = !w_done && k >= w_dly;
      aw_hs = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_hs  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      step();
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      k++;
    end
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    k = 0;
    while (!bus.S_AXI_BVALID && k < 64) begin step(); k++; end
    if (!bus.S_AXI_BVALID) begin
      total++;
      $display("FAIL write_timeout addr=%h: no BVALID within bound", addr);
    end
    t_b = cyc;
    bresp = bus.S_AXI_BRESP;
    b_stable = 1'b1;
    for (int i = 0; i < b_dly; i++) begin
      step();
      if (!bus.S_AXI_BVALID) b_stable = 1'b0;
    end
    bus.S_AXI_BREADY = 1'b1;
    step();
    bus.S_AXI_BREADY = 1'b0;
    b_after = bus.S_AXI_BVALID;
  endtask

  task automatic axi_read(input logic [3:0] addr, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp, output logic stable);
    int k = 0;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARPROT  = 3'($urandom);
    bus.S_AXI_ARVALID = 1'b1;
    while (!bus.S_AXI_ARREADY && k < 64) begin step(); k++; end
    step();
    bus.S_AXI_ARVALID = 1'b0;
    k = 0;
    while (!bus.S_AXI_RVALID && k < 64) begin step(); k++; end
    if (!bus.S_AXI_RVALID) begin
      total++;
      $display("FAIL read_timeout addr=%h: no RVALID within bound", addr);
    end
    data = bus.S_AXI_RDATA;
    resp = bus.S_AXI_RRESP;
    stable = 1'b1;
    for (int i = 0; i < r_dly; i++) begin
      step();
      if (!bus.S_AXI_RVALID || bus.S_AXI_RDATA !== data) stable = 1'b0;
    end
    bus.S_AXI_RREADY = 1'b1;
    step();
    bus.S_AXI_RREADY = 1'b0;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data, output int t_b);
    logic [1:0] r; logic a, s;
    axi_write(addr, data, 4'hF, 0, 0, 0, t_b, r, a, s);
  endtask

  task automatic rd(input logic [3:0] addr, output logic [31:0] data);
    logic [1:0] r; logic s;
    axi_read(addr, 0, data, r, s);
  endtask

  task automatic apply_reset();
    ARESET = 1'b1;
    step(); step(); step();
    ARESET = 1'b0;
    step();
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] d;
    step(); step();
    total++;
    if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID,
         bus.S_AXI_RVALID, irq, bus.S_AXI_BRESP, bus.S_AXI_RRESP} !== 10'd0 || bus.S_AXI_RDATA !== 32'd0)
      $display("FAIL reset_outputs got ready=%b%b%b bv=%b rv=%b irq=%b rdata=%h want all 0",
               bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID,
               bus.S_AXI_RVALID, irq, bus.S_AXI_RDATA);
    else passed++;
    ARESET = 1'b0;
    #1;
    total++;
    if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b000)
      $display("FAIL ready_before_edge got %b%b%b want 000",
               bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY);
    else passed++;
    step();
    total++;
    if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b111)
      $display("FAIL ready_after_edge got %b%b%b want 111",
               bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      rd(4'(i * 4), d);
      total++;
      if (d !== 32'd0) $display("FAIL reset_reg%0d got %h want 00000000", i, d);
      else passed++;
    end
  endtask

  task automatic test_basic_rw();
    logic [31:0] d; logic [1:0] br, rr; logic a, s; int t;
    axi_write(4'h0, 32'h1, 4'hF, 0, 0, 0, t, br, a, s); m_opa = 32'h1;
    total++;
    if (br !== 2'b00) $display("FAIL bresp_opa got %b want 00", br); else passed++;
    axi_write(4'h4, 32'h2, 4'hF, 0, 0, 0, t, br, a, s); m_opb = 32'h2;
    axi_read(4'h0, 0, d, rr, s);
    total++;
    if (d !== 32'h1 || rr !== 2'b00) $display("FAIL read_opa got %h/%b want 00000001/00", d, rr);
    else passed++;
    axi_read(4'h4, 0, d, rr, s);
    total++;
    if (d !== 32'h2 || rr !== 2'b00) $display("FAIL read_opb got %h/%b want 00000002/00", d, rr);
    else passed++;
  endtask

  task automatic test_strobe();
    logic [31:0] d, data, exp; logic [1:0] br, rr; logic a, s; int t;
    logic [3:0] addr, strb; logic [1:0] idx;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 2))
        0: idx = 2'd0;
        1: idx = 2'd1;
        default: idx = 2'd3;
      endcase
      addr = {idx, 2'($urandom)};
      data = $urandom;
      strb = 4'($urandom);
      axi_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                t, br, a, s);
      if (idx == 2'd0) m_opa = merge(m_opa, data, strb);
      if (idx == 2'd1) m_opb = merge(m_opb, data, strb);
      total++;
      if (br !== 2'b00 || a !== 1'b0 || s !== 1'b1)
        $display("FAIL strobe_wr%0d bresp=%b after=%b stable=%b want 00/0/1", i, br, a, s);
      else passed++;
      axi_read({idx, 2'($urandom)}, $urandom_range(0, 3), d, rr, s);
      exp = (idx == 2'd0) ? m_opa : (idx == 2'd1) ? m_opb : m_result;
      total++;
      if (d !== exp || rr !== 2'b00 || s !== 1'b1)
        $display("FAIL strobe_rd%0d reg=%0d got %h/%b stable=%b want %h/00", i, idx, d, rr, s, exp);
      else passed++;
    end
  endtask

  task automatic run_gcd(input logic [31:0] a, input logic [31:0] b, input int tag);
    logic [31:0] d; int t_b, t_i, k, lat;
    wr(4'h0, a, t_b); m_opa = a;
    wr(4'h4, b, t_b); m_opb = b;
    wr(4'h8, 32'h1, t_b);
    lat = ref_latency(a, b);
    k = 0;
    while (!irq && k < lat + 50) begin step(); k++; end
    t_i = cyc;
    m_busy = 1'b0; m_done = 1'b1; m_result = ref_gcd(a, b);
    total++;
    if (!irq || t_i - t_b !== lat)
      $display("FAIL gcd_latency[%0d] a=%0d b=%0d irq=%b got %0d want %0d", tag, a, b, irq, t_i - t_b, lat);
    else passed++;
    rd(4'hC, d);
    total++;
    if (d !== m_result) $display("FAIL gcd_result[%0d] a=%0d b=%0d got %0d want %0d", tag, a, b, d, m_result);
    else passed++;
    rd(4'h8, d);
    total++;
    if (d !== m_status() || irq !== 1'b1)
      $display("FAIL gcd_status[%0d] got %h irq=%b want %h irq=1", tag, d, irq, m_status());
    else passed++;
  endtask

  task automatic test_gcd_fixed();
    run_gcd(32'd12, 32'd8, 0);
    run_gcd(32'd0, 32'd7, 1);
    run_gcd(32'd0, 32'd0, 2);
    run_gcd(32'd7, 32'd0, 3);
    run_gcd(32'd21, 32'd21, 4);
  endtask

  task automatic test_busy_poll();
    logic [31:0] d; int t; int k = 0; bit seen_busy;
    wr(4'h0, 32'd12, t); m_opa = 32'd12;
    wr(4'h4, 32'd8, t);  m_opb = 32'd8;
    wr(4'h8, 32'h1, t);  m_busy = 1'b1; m_done = 1'b0;
    rd(4'h8, d);
    seen_busy = (d === 32'h2);
    total++;
    if (d !== m_status()) $display("FAIL poll_busy got %h want %h", d, m_status());
    else passed++;
    while (d !== 32'h4 && k < 20) begin rd(4'h8, d); k++; end
    m_busy = 1'b0; m_done = 1'b1; m_result = ref_gcd(32'd12, 32'd8);
    total++;
    if (d !== m_status() || !seen_busy || irq !== 1'b1)
      $display("FAIL poll_done got %h busy_seen=%b irq=%b want %h 1 1", d, seen_busy, irq, m_status());
    else passed++;
    rd(4'hC, d);
    total++;
    if (d !== 32'd4) $display("FAIL poll_result got %0d want 4", d); else passed++;
  endtask

  task automatic test_random_gcd();
    logic [31:0] a, b;
    for (int i = 0; i < 6; i++) begin
      a = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 60));
      b = 32'($urandom_range(1, 60));
      if ($urandom_range(0, 1) == 1) run_gcd(a, b, 10 + i);
      else run_gcd(b, a, 10 + i);
    end
  endtask

  task automatic test_write_order();
    logic [31:0] d, v; logic [1:0] br; logic a, s; int t;
    v = $urandom;
    axi_write(4'h0, v, 4'hF, 0, 3, 0, t, br, a, s); m_opa = v;
    total++;
    if (a !== 1'b0 || br !== 2'b00) $display("FAIL aw_first one_b after=%b bresp=%b want 0/00", a, br);
    else passed++;
    v = $urandom;
    axi_write(4'h4, v, 4'hF, 3, 0, 0, t, br, a, s); m_opb = v;
    total++;
    if (a !== 1'b0 || br !== 2'b00) $display("FAIL w_first one_b after=%b bresp=%b want 0/00", a, br);
    else passed++;
    v = $urandom;
    axi_write(4'h0, v, 4'hF, 1, 0, 5, t, br, a, s); m_opa = v;
    total++;
    if (a !== 1'b0 || s !== 1'b1) $display("FAIL bready_hold stable=%b after=%b want 1/0", s, a);
    else passed++;
    rd(4'h0, d);
    total++;
    if (d !== m_opa) $display("FAIL order_opa got %h want %h", d, m_opa); else passed++;
    rd(4'h4, d);
    total++;
    if (d !== m_opb) $display("FAIL order_opb got %h want %h", d, m_opb); else passed++;
  endtask

  task automatic test_simultaneous();
    logic [31:0] d_pre, d; logic [1:0] br, rr; logic a, s, s2; int t_b, t;
    logic [31:0] pre;
    wr(4'h0, 32'd12, t); m_opa = 32'd12;
    wr(4'h4, 32'd8, t);  m_opb = 32'd8;
    pre = m_status();
    fork
      axi_write(4'h8, 32'h1, 4'hF, 0, 0, 0, t_b, br, a, s);
      begin step(); axi_read(4'h8, 0, d_pre, rr, s2); end
    join
    m_busy = 1'b1; m_done = 1'b0;
    total++;
    if (d_pre !== pre) $display("FAIL simul_status got %h want %h", d_pre, pre); else passed++;
    rd(4'h8, d);
    total++;
    if (d !== m_status()) $display("FAIL simul_after got %h want %h", d, m_status()); else passed++;
    t = 0;
    while (!irq && t < 40) begin step(); t++; end
    m_busy = 1'b0; m_done = 1'b1; m_result = 32'd4;
    rd(4'hC, d);
    total++;
    if (d !== m_result || irq !== 1'b1) $display("FAIL simul_result got %0d irq=%b want 4 1", d, irq);
    else passed++;
  endtask

  task automatic test_start_during_calc();
    logic [31:0] d, prev; int t_b, t, t_i, k;
    prev = m_result;
    wr(4'h0, 32'd100, t); m_opa = 32'd100;
    wr(4'h4, 32'd1, t);   m_opb = 32'd1;
    wr(4'h8, 32'h1, t_b); m_busy = 1'b1; m_done = 1'b0;
    wr(4'h0, 32'd6, t); m_opa = 32'd6;
    wr(4'h4, 32'd4, t); m_opb = 32'd4;
    wr(4'h8, 32'h1, t);  // engine busy: must be ignored
    rd(4'hC, d);
    total++;
    if (d !== prev || irq !== 1'b0) $display("FAIL restart_ignored result=%0d irq=%b want %0d 0", d, irq, prev);
    else passed++;
    k = 0;
    while (!irq && k < 200) begin step(); k++; end
    t_i = cyc;
    m_busy = 1'b0; m_done = 1'b1; m_result = ref_gcd(32'd100, 32'd1);
    total++;
    if (t_i - t_b !== ref_latency(32'd100, 32'd1))
      $display("FAIL restart_latency got %0d want %0d", t_i - t_b, ref_latency(32'd100, 32'd1));
    else passed++;
    rd(4'hC, d);
    total++;
    if (d !== m_result) $display("FAIL restart_result got %0d want %0d", d, m_result); else passed++;
  endtask

  task automatic test_big_operand();
    logic [31:0] d, prev; int t;
    prev = m_result;
    wr(4'h0, 32'hFFFF_FFFF, t); m_opa = 32'hFFFF_FFFF;
    wr(4'h4, 32'h1, t);         m_opb = 32'h1;
    wr(4'h8, 32'h1, t);         m_busy = 1'b1; m_done = 1'b0;
    rd(4'h8, d);
    total++;
    if (d !== m_status()) $display("FAIL big_busy got %h want %h", d, m_status()); else passed++;
    wr(4'h8, 32'h1, t);
    rd(4'h8, d);
    total++;
    if (d !== m_status() || irq !== 1'b0) $display("FAIL big_restart got %h irq=%b want %h 0", d, irq, m_status());
    else passed++;
    rd(4'hC, d);
    total++;
    if (d !== prev) $display("FAIL big_result_held got %0d want %0d", d, prev); else passed++;
    apply_reset();
  endtask

  task automatic test_reset_during_calc();
    logic [31:0] d; int t;
    wr(4'h0, 32'd1000, t); m_opa = 32'd1000;
    wr(4'h4, 32'd1, t);    m_opb = 32'd1;
    wr(4'h8, 32'h1, t);    m_busy = 1'b1; m_done = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rd(4'h8, d);
    total++;
    if (d !== m_status()) $display("FAIL rst_busy got %h want %h", d, m_status()); else passed++;
    bus.S_AXI_ARADDR  = 4'h8;
    bus.S_AXI_ARVALID = 1'b1;
    step();
    bus.S_AXI_ARVALID = 1'b0;
    #2 ARESET = 1'b1;
    #1;
    model_reset();
    total++;
    if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID,
         bus.S_AXI_RVALID, irq} !== 6'd0 || bus.S_AXI_RDATA !== 32'd0)
      $display("FAIL rst_async got rdy=%b%b%b bv=%b rv=%b irq=%b rdata=%h want 0",
               bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID,
               bus.S_AXI_RVALID, irq, bus.S_AXI_RDATA);
    else passed++;
    step(); step();
    ARESET = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      rd(4'(i * 4), d);
      total++;
      if (d !== 32'd0) $display("FAIL rst_reg%0d got %h want 00000000", i, d);
      else passed++;
    end
    run_gcd(32'd9, 32'd6, 99);
  endtask

  initial begin
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    test_reset();
    test_basic_rw();
    test_strobe();
    test_gcd_fixed();
    test_busy_poll();
    test_random_gcd();
    test_write_order();
    test_simultaneous();
    test_start_during_calc();
    test_big_operand();
    test_reset_during_calc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gcd_axil_slave.md
GCD_AXIL_SLAVE -- requirements
Module: gcd_axil_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width (4 registers).
REQ-003 SHALL have port ACLK  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port ARESET  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports S_AXI_AWADDR in ADDR_W, S_AXI_AWPROT in 3, S_AXI_AWVALID in 1, S_AXI_AWREADY out 1 for the write address channel.
REQ-006 SHALL have ports S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1 for the write data channel.
REQ-007 SHALL have ports S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1 for the write response channel.
REQ-008 SHALL have ports S_AXI_ARADDR in ADDR_W, S_AXI_ARPROT in 3, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1 for the read address channel.
REQ-009 SHALL have ports S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1 for the read data channel.
REQ-010 SHALL have port irq  out  1  level interrupt, equal to STATUS.done.

Function
REQ-011 Register map by addr[3:2]: 0x0 OPA (RW), 0x4 OPB (RW), 0x8 CTRL/STATUS, 0xC RESULT (RO); addr[1:0] ignored; every access returns RESP=OKAY.
REQ-012 Write path: AWREADY and WREADY held high in each channel until it handshakes; each captured independently; write commits in the cycle both are held; BVALID asserts the next cycle; no new AW/W accepted while BVALID=1; BVALID drops on BREADY.
REQ-013 Writes to OPA/OPB honour WSTRB per byte; writes to RESULT are ignored (OKAY).
REQ-014 CTRL write: bit0=1 while state IDLE or DONE latches OPA/OPB into the engine and starts it; ignored while CALC; bit0 never reads back as 1.
REQ-015 CTRL read: bit0=0, bit1=busy (state CALC), bit2=done (state DONE), bits 31:3 = 0.
REQ-016 Read path: ARREADY high when RVALID=0; RVALID asserts the cycle after the AR handshake, RDATA held stable until RREADY; one outstanding read.
REQ-017 Simultaneous read and write in one cycle: both serviced; a read of STATUS in the same cycle as a start write returns the pre-write value.
REQ-018 Engine FSM: IDLE -> CALC on start; in CALC each cycle: if a==0 or b==0 or a==b -> DONE with RESULT=max(a,b) (0 if both zero); else larger operand -= smaller.
REQ-019 Latency: DONE reached after (subtraction steps + 1) CALC cycles; gcd(12,8) = 3 CALC cycles.
REQ-020 DONE -> CALC on a new start (done clears the same edge); DONE is otherwise sticky; RESULT holds until the next DONE.
REQ-021 All arithmetic unsigned 32-bit; no overflow possible (subtraction of smaller from larger).

Reset
REQ-022 On ARESET: all READY/VALID outputs 0, BRESP/RRESP 0, RDATA 0, OPA/OPB/RESULT 0, state IDLE, irq 0; asserting ARESET mid-transaction or mid-CALC aborts with no response issued.
REQ-023 AWREADY/WREADY/ARREADY rise no earlier than the first ACLK edge after ARESET deasserts.

Structure
REQ-024 Shared package gcd_pkg SHALL hold the register offset constants, the CTRL bit indices, the engine state enum (IDLE, CALC, DONE) and the RESP_OKAY constant.
REQ-025 The engine SHALL be the sub-module gcd_core (ports: clk, reset, start, a, b, busy, done, result); gcd_axil_slave holds the AXI logic and the registers.

Verification
REQ-026 Write 0x1,0x2 to 0x0,0x4, then read 0x0,0x4 -> 0x00000001, 0x00000002, BRESP/RRESP=OKAY.
REQ-027 OPA=12, OPB=8, CTRL=1, poll 0x8 -> busy seen, then 0x4 (done); RESULT=4; irq=1.
REQ-028 OPA=0, OPB=7, start -> DONE after 1 CALC cycle, RESULT=7; OPA=OPB=0 -> RESULT=0.
REQ-029 OPA=0xFFFFFFFF, OPB=1, start -> RESULT=1; a second start issued during CALC is ignored (RESULT unchanged, no early done).
REQ-030 Write with AW 3 cycles before W, W 3 cycles before AW, and BREADY held low 5 cycles -> exactly one BVALID per write, data committed correctly.
REQ-031 Assert ARESET during CALC (OPA=1000, OPB=1) -> all registers 0, state IDLE, irq=0, next start with 9,6 yields 3.
